// File: rtl/pipe_pkg.sv
// Shared EX/MEM pipeline definitions: destination-select codes and the packed control bundle.
package pipe_pkg;

    localparam logic [1:0] DST_RT   = 2'b00;
    localparam logic [1:0] DST_RD   = 2'b01;
    localparam logic [1:0] DST_LINK = 2'b10;

    typedef struct packed {
        logic jump;
        logic branch;
        logic bne;
        logic mem_read;
        logic mem_to_reg;
        logic mem_write;
        logic reg_write;
    } ex_mem_ctrl_t;

endpackage

// File: rtl/ex_mem_wreg_sel.sv
// Destination-register select (rt / rd / link) with the $zero write kill.
module ex_mem_wreg_sel
    import pipe_pkg::*;
#(
    parameter int RADDR_W  = 5,
    parameter int LINK_REG = 31
) (
    input  logic [1:0]         i_dst_sel,
    input  logic [RADDR_W-1:0] i_rt,
    input  logic [RADDR_W-1:0] i_rd,
    input  logic               i_reg_write,
    output logic [RADDR_W-1:0] o_write_reg,
    output logic               o_reg_write
);

    logic [RADDR_W-1:0] w_sel;

    always_comb begin
        w_sel = i_rt;
        case (i_dst_sel)
            DST_RD:   w_sel = i_rd;
            DST_LINK: w_sel = RADDR_W'(LINK_REG);
            default:  w_sel = i_rt;
        endcase
    end

    // Register 0 is hard-wired, so a write aimed at it is dropped here.
    assign o_write_reg = w_sel;
    assign o_reg_write = i_reg_write & (w_sel != '0);

endmodule

// File: rtl/pr_ex_mem_pipe.sv
// EX/MEM pipeline register with valid, stall/flush and pre-resolved branch-taken.
// Optional event counters (stall/flush/bubble) are built when PR_EX_MEM_STATS_EN is defined.
module pr_ex_mem_pipe
    import pipe_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int RADDR_W  = 5,
    parameter int LINK_REG = 31,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               valid_in,
    input  logic               jump_in,
    input  logic               branch_in,
    input  logic               bne_in,
    input  logic               mem_read_in,
    input  logic               mem_to_reg_in,
    input  logic               mem_write_in,
    input  logic               reg_write_in,
    input  logic [1:0]         dst_sel_in,
    input  logic               zero_in,
    input  logic [XLEN-1:0]    alu_result_in,
    input  logic [XLEN-1:0]    reg_data2_in,
    input  logic [XLEN-1:0]    pc_plus4_in,
    input  logic [31:0]        instru_in,
    output logic               valid,
    output logic               jump,
    output logic               branch,
    output logic               bne,
    output logic               mem_read,
    output logic               mem_to_reg,
    output logic               mem_write,
    output logic               reg_write,
    output logic               br_taken,
    output logic               zero,
    output logic [XLEN-1:0]    alu_result,
    output logic [XLEN-1:0]    reg_data2,
    output logic [XLEN-1:0]    pc_plus4,
    output logic [RADDR_W-1:0] write_reg,
    output logic [31:0]        instru
`ifdef PR_EX_MEM_STATS_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
`endif
);

    if (RADDR_W < 1 || RADDR_W > 16 || CNT_W < 1 || XLEN < 1 ||
        LINK_REG < 0 || LINK_REG >= (1 << RADDR_W)) begin : g_param_chk
        $error("pr_ex_mem_pipe: illegal parameter combination");
    end

    logic [RADDR_W-1:0] w_write_reg;
    logic               w_reg_write_ok;
    ex_mem_ctrl_t       w_ctrl_in;
    logic               w_br_taken;

    ex_mem_wreg_sel #(
        .RADDR_W  (RADDR_W),
        .LINK_REG (LINK_REG)
    ) u_wreg_sel (
        .i_dst_sel   (dst_sel_in),
        .i_rt        (instru_in[RADDR_W-1+16:16]),
        .i_rd        (instru_in[RADDR_W-1+11:11]),
        .i_reg_write (reg_write_in),
        .o_write_reg (w_write_reg),
        .o_reg_write (w_reg_write_ok)
    );

    // Every control bit is qualified by valid_in so a non-valid load becomes a bubble.
    assign w_ctrl_in = '{
        jump:       jump_in       & valid_in,
        branch:     branch_in     & valid_in,
        bne:        bne_in        & valid_in,
        mem_read:   mem_read_in   & valid_in,
        mem_to_reg: mem_to_reg_in & valid_in,
        mem_write:  mem_write_in  & valid_in,
        reg_write:  w_reg_write_ok & valid_in
    };

    assign w_br_taken = valid_in & ((branch_in & zero_in) | (bne_in & ~zero_in));

    ex_mem_ctrl_t       r_ctrl;
    logic               r_valid;
    logic               r_br_taken;
    logic               r_zero;
    logic [XLEN-1:0]    r_alu_result;
    logic [XLEN-1:0]    r_reg_data2;
    logic [XLEN-1:0]    r_pc_plus4;
    logic [RADDR_W-1:0] r_write_reg;
    logic [31:0]        r_instru;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl       <= '0;
            r_valid      <= 1'b0;
            r_br_taken   <= 1'b0;
            r_zero       <= 1'b0;
            r_alu_result <= '0;
            r_reg_data2  <= '0;
            r_pc_plus4   <= '0;
            r_write_reg  <= '0;
            r_instru     <= '0;
        end else if (flush) begin
            r_ctrl       <= '0;
            r_valid      <= 1'b0;
            r_br_taken   <= 1'b0;
            r_zero       <= 1'b0;
            r_alu_result <= '0;
            r_reg_data2  <= '0;
            r_pc_plus4   <= '0;
            r_write_reg  <= '0;
            r_instru     <= '0;
        end else if (!stall) begin
            r_ctrl       <= w_ctrl_in;
            r_valid      <= valid_in;
            r_br_taken   <= w_br_taken;
            r_zero       <= zero_in;
            r_alu_result <= alu_result_in;
            r_reg_data2  <= reg_data2_in;
            r_pc_plus4   <= pc_plus4_in;
            r_write_reg  <= w_write_reg;
            r_instru     <= instru_in;
        end
    end

    assign valid      = r_valid;
    assign jump       = r_ctrl.jump;
    assign branch     = r_ctrl.branch;
    assign bne        = r_ctrl.bne;
    assign mem_read   = r_ctrl.mem_read;
    assign mem_to_reg = r_ctrl.mem_to_reg;
    assign mem_write  = r_ctrl.mem_write;
    assign reg_write  = r_ctrl.reg_write;
    assign br_taken   = r_br_taken;
    assign zero       = r_zero;
    assign alu_result = r_alu_result;
    assign reg_data2  = r_reg_data2;
    assign pc_plus4   = r_pc_plus4;
    assign write_reg  = r_write_reg;
    assign instru     = r_instru;

`ifdef PR_EX_MEM_STATS_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    // Counters saturate at all-ones; a stall edge only counts when flush does not override it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (flush && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            if (!flush && stall && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (!flush && !stall && !valid_in && r_bubble_cnt != '1)
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
